// File: rtl/inst_fetch_align.sv
// Instruction fetch/align unit: prefetches aligned words into a 2-entry queue and
// extracts the 16/32-bit instruction at pc, including word-straddling encodings.
module inst_fetch_align #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              inst_comp
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fa, qa;
  logic [31:0]       q0, q1;
  logic              v0, v1;

  logic              hit, is16, pop, push;
  logic [15:0]       h;
  logic [1:0]        occ_nxt;
  logic              unused;

  assign unused = ^{pc[0], qa[1:0]};

  // Extraction is purely combinational so the PC controller sees inst in the same cycle.
  always_comb begin
    inst       = '0;
    inst_valid = 1'b0;
    inst_comp  = 1'b0;
    hit        = v0 && (pc[ADDR_W-1:2] == qa[ADDR_W-1:2]);
    h          = pc[1] ? q0[31:16] : q0[15:0];
    is16       = (h[1:0] != 2'b11);
    if (hit && !flush) begin
      if (is16) begin
        inst       = {16'h0, h};
        inst_valid = 1'b1;
        inst_comp  = 1'b1;
      end else if (!pc[1]) begin
        inst       = q0;
        inst_valid = 1'b1;
      end else if (v1) begin
        inst       = {q1[15:0], h};
        inst_valid = 1'b1;
      end
    end
  end

  // Head word is retired once the consumed instruction reaches into the next word.
  assign pop     = inst_valid && !stall && (pc[1] || !is16);
  assign push    = (state == WAIT) && rsp_valid && !flush;
  assign occ_nxt = 2'(v0) + 2'(v1) + 2'(push) - 2'(pop);

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    req_addr  = '0;
    case (state)
      IDLE: if (!flush) state_nxt = REQ;
      REQ: begin
        req_valid = 1'b1;
        req_addr  = fa;
        if (flush)          state_nxt = req_ready ? DRAIN : IDLE;
        else if (req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush)          state_nxt = rsp_valid ? IDLE : DRAIN;
        else if (rsp_valid) state_nxt = (occ_nxt < 2'd2) ? REQ : FULL;
      end
      FULL: begin
        if (flush)    state_nxt = IDLE;
        else if (pop) state_nxt = REQ;
      end
      // The single outstanding response is swallowed regardless of further flushes.
      DRAIN: if (rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fa    <= '0;
      qa    <= '0;
      q0    <= '0;
      q1    <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && !flush) fa <= {pc[ADDR_W-1:2], 2'b00};
      else if (push)               fa <= fa + FOUR;
      if (flush) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
      end else begin
        case ({push, pop})
          2'b01: begin
            q0 <= q1;
            v0 <= v1;
            v1 <= 1'b0;
            qa <= qa + FOUR;
          end
          2'b10: begin
            if (!v0) begin
              q0 <= rsp_data;
              v0 <= 1'b1;
              qa <= fa;
            end else begin
              q1 <= rsp_data;
              v1 <= 1'b1;
            end
          end
          2'b11: begin
            qa <= qa + FOUR;
            if (v1) begin
              q0 <= q1;
              q1 <= rsp_data;
            end else begin
              q0 <= rsp_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
